// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream read path: FSM encoding, default widths
// and a constant-foldable clog2.
package axis_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int AXIS_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RECV = 2'b01,
    S_WAIT = 2'b10
  } axis_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through FIFO with extended pointers; the head entry is visible
// combinationally and occupancy is the pointer difference.
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int pWIDTH = AXIS_DATA_WIDTH + 1,
  parameter int pDEPTH = 4,
  localparam int AW = clog2(pDEPTH)
) (
  input  logic              axis_clk,
  input  logic              rst,
  input  logic              push,
  input  logic [pWIDTH-1:0] wdata,
  input  logic              pop,
  output logic [pWIDTH-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Guard both ports locally so a misbehaving caller cannot corrupt the pointers.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/axistream_read.sv
// AXI4-Stream sink for the FIR output: buffers one frame in a FWFT FIFO, hands it
// to a local consumer and pulses frame_done once the frame has fully drained.
module axistream_read
  import axis_pkg::*;
#(
  parameter int pDATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int pFIFO_DEPTH = 4,
  parameter int pCNT_WIDTH  = AXIS_CNT_WIDTH,
  localparam int AW = clog2(pFIFO_DEPTH)
) (
  input  logic                   axis_clk,
  input  logic                   axistream_r_rst,
  input  logic                   en,
  input  logic                   sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast,
  output logic                   sm_tready,
  input  logic                   rd_en,
  output logic [pDATA_WIDTH-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   rd_last,
  output logic [pCNT_WIDTH-1:0]  word_cnt,
  output logic [AW:0]            fifo_level,
  output logic                   frame_done
);

  localparam logic [AW:0]         LVL_ONE = (AW + 1)'(1);
  localparam logic [pCNT_WIDTH-1:0] CNT_ONE = pCNT_WIDTH'(1);

  axis_state_e          state;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 pop;
  logic [pDATA_WIDTH:0] head;

  // tready depends only on registered state and pointers, never on tvalid.
  assign sm_tready = (state == S_RECV) && !full;
  assign accept    = sm_tvalid && sm_tready;
  assign rd_valid  = !empty;
  assign pop       = rd_en && rd_valid;
  assign rd_data   = head[pDATA_WIDTH-1:0];
  assign rd_last   = rd_valid && head[pDATA_WIDTH];

  axis_sync_fifo #(
    .pWIDTH (pDATA_WIDTH + 1),
    .pDEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .axis_clk (axis_clk),
    .rst      (axistream_r_rst),
    .push     (accept),
    .wdata    ({sm_tlast, sm_tdata}),
    .pop      (pop),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );

  always_ff @(posedge axis_clk or posedge axistream_r_rst) begin
    if (axistream_r_rst) begin
      state      <= S_IDLE;
      word_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            state    <= S_RECV;
            word_cnt <= '0;
          end
        end
        S_RECV: begin
          if (accept) begin
            if (word_cnt != '1) word_cnt <= word_cnt + CNT_ONE;
            if (sm_tlast) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A pop of the final entry on this edge counts as drained.
          if (empty || ((fifo_level == LVL_ONE) && pop)) begin
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axistream_read.sv
// Directed bench for axistream_read: per-cycle vector table plus hand-written
// sequences for sustained throughput and asynchronous reset mid-frame.
module tb_axistream_read;

  logic        axis_clk;
  logic        axistream_r_rst;
  logic        en;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        sm_tready;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic [15:0] word_cnt;
  logic [2:0]  fifo_level;
  logic        frame_done;

  axistream_read dut (
    .axis_clk        (axis_clk),
    .axistream_r_rst (axistream_r_rst),
    .en              (en),
    .sm_tvalid       (sm_tvalid),
    .sm_tdata        (sm_tdata),
    .sm_tlast        (sm_tlast),
    .sm_tready       (sm_tready),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_last         (rd_last),
    .word_cnt        (word_cnt),
    .fifo_level      (fifo_level),
    .frame_done      (frame_done)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic        en;
    logic        tv;
    logic [31:0] td;
    logic        tl;
    logic        rd;
    logic        x_tready;
    logic        x_rv;
    logic [31:0] x_rdata;
    logic        x_rlast;
    logic [15:0] x_wc;
    logic [2:0]  x_lvl;
    logic        x_fd;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] pop_q[$];
  int          n_vec;
  int          n_err;
  int          fd_cnt;

  always @(posedge axis_clk) begin
    if (!axistream_r_rst && rd_en && rd_valid) pop_q.push_back(rd_data);
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic e, input logic tv, input logic [31:0] td, input logic tl,
                       input logic rd, input logic x_tready, input logic x_rv,
                       input logic [31:0] x_rdata, input logic x_rlast, input logic [15:0] x_wc,
                       input logic [2:0] x_lvl, input logic x_fd);
    vec_t v;
    v.en = e; v.tv = tv; v.td = td; v.tl = tl; v.rd = rd;
    v.x_tready = x_tready; v.x_rv = x_rv; v.x_rdata = x_rdata; v.x_rlast = x_rlast;
    v.x_wc = x_wc; v.x_lvl = x_lvl; v.x_fd = x_fd;
    vq.push_back(v);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge axis_clk);
      if (fd_cnt > 0) seen = 1;
    end
    if (!seen) begin
      n_err++;
      $display("FAIL %s: frame_done not seen within %0d cycles", name, budget);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; fd_cnt = 0;
    axistream_r_rst = 1'b1;
    en = 0; sm_tvalid = 0; sm_tdata = '0; sm_tlast = 0; rd_en = 0;

    // en tv  data          tl rd | tready rv rdata         rlast wc lvl fd
    // 4-beat frame with the consumer always popping
    add_v(1, 0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 0, 0, 0);
    add_v(0, 1, 32'h11,       0, 1,  1, 0, 32'h0,        0, 0, 0, 0);
    add_v(0, 1, 32'h22,       0, 1,  1, 1, 32'h11,       0, 1, 1, 0);
    add_v(0, 1, 32'h33,       0, 1,  1, 1, 32'h22,       0, 2, 1, 0);
    add_v(0, 1, 32'h44,       1, 1,  1, 1, 32'h33,       0, 3, 1, 0);
    add_v(0, 0, 32'h0,        0, 1,  0, 1, 32'h44,       1, 4, 1, 0);
    add_v(0, 0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 4, 0, 1);
    add_v(0, 0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 4, 0, 0);
    // single-beat frame
    add_v(1, 0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 4, 0, 0);
    add_v(0, 1, 32'hDEADBEEF, 1, 1,  1, 0, 32'h0,        0, 0, 0, 0);
    add_v(0, 0, 32'h0,        0, 1,  0, 1, 32'hDEADBEEF, 1, 1, 1, 0);
    add_v(0, 0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 1, 0, 1);
    add_v(0, 0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 1, 0, 0);
    // beats offered while idle are refused
    add_v(0, 1, 32'h55,       0, 0,  0, 0, 32'h0,        0, 1, 0, 0);
    add_v(0, 1, 32'h55,       0, 0,  0, 0, 32'h0,        0, 1, 0, 0);
    // 6-beat frame into a depth-4 FIFO with the consumer stalled, then draining
    add_v(1, 0, 32'h0,        0, 0,  0, 0, 32'h0,        0, 1, 0, 0);
    add_v(0, 1, 32'hA1,       0, 0,  1, 0, 32'h0,        0, 0, 0, 0);
    add_v(0, 1, 32'hA2,       0, 0,  1, 1, 32'hA1,       0, 1, 1, 0);
    add_v(0, 1, 32'hA3,       0, 0,  1, 1, 32'hA1,       0, 2, 2, 0);
    add_v(0, 1, 32'hA4,       0, 0,  1, 1, 32'hA1,       0, 3, 3, 0);
    add_v(0, 1, 32'hA5,       0, 0,  0, 1, 32'hA1,       0, 4, 4, 0);
    add_v(0, 1, 32'hA5,       0, 1,  0, 1, 32'hA1,       0, 4, 4, 0);
    add_v(0, 1, 32'hA5,       0, 1,  1, 1, 32'hA2,       0, 4, 3, 0);
    add_v(0, 1, 32'hA6,       1, 1,  1, 1, 32'hA3,       0, 5, 3, 0);
    add_v(0, 1, 32'h77,       0, 0,  0, 1, 32'hA4,       0, 6, 3, 0);
    add_v(0, 1, 32'h77,       0, 1,  0, 1, 32'hA4,       0, 6, 3, 0);
    add_v(0, 0, 32'h0,        0, 1,  0, 1, 32'hA5,       0, 6, 2, 0);
    add_v(0, 0, 32'h0,        0, 1,  0, 1, 32'hA6,       1, 6, 1, 0);
    add_v(0, 0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 6, 0, 1);
    add_v(0, 0, 32'h0,        0, 0,  0, 0, 32'h0,        0, 6, 0, 0);

    #2;
    chk("rst_tready", 32'(sm_tready), 32'd0);
    chk("rst_rvalid", 32'(rd_valid), 32'd0);
    chk("rst_rlast", 32'(rd_last), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_wc", 32'(word_cnt), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    repeat (2) @(negedge axis_clk);
    axistream_r_rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge axis_clk);
      en = vq[i].en; sm_tvalid = vq[i].tv; sm_tdata = vq[i].td;
      sm_tlast = vq[i].tl; rd_en = vq[i].rd;
      #1;
      chk($sformatf("v%0d_tready", i), 32'(sm_tready), 32'(vq[i].x_tready));
      chk($sformatf("v%0d_rvalid", i), 32'(rd_valid), 32'(vq[i].x_rv));
      if (vq[i].x_rv) begin
        chk($sformatf("v%0d_rdata", i), rd_data, vq[i].x_rdata);
        chk($sformatf("v%0d_rlast", i), 32'(rd_last), 32'(vq[i].x_rlast));
      end
      chk($sformatf("v%0d_wc", i), 32'(word_cnt), 32'(vq[i].x_wc));
      chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'(vq[i].x_lvl));
      chk($sformatf("v%0d_fd", i), 32'(frame_done), 32'(vq[i].x_fd));
    end

    // Sustained push+pop with level held at 2; 20 beats wrap the pointers several times.
    pop_q.delete(); fd_cnt = 0;
    @(negedge axis_clk);
    en = 1; sm_tvalid = 0; sm_tlast = 0; rd_en = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge axis_clk);
      en = 0; sm_tvalid = 1; sm_tdata = 32'(i); sm_tlast = (i == 20); rd_en = (i >= 3);
      #1;
      if (i >= 3) begin
        chk($sformatf("sus_level_%0d", i), 32'(fifo_level), 32'd2);
        chk($sformatf("sus_tready_%0d", i), 32'(sm_tready), 32'd1);
      end
    end
    @(negedge axis_clk);
    sm_tvalid = 0; sm_tlast = 0;
    wait_done("sus_done", 20);
    @(negedge axis_clk);
    chk("sus_wc", 32'(word_cnt), 32'd20);
    chk("sus_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("sus_pop_cnt", 32'(pop_q.size()), 32'd20);
    for (int i = 0; i < pop_q.size() && i < 20; i++)
      chk($sformatf("sus_data_%0d", i), pop_q[i], 32'(i + 1));

    // Asynchronous reset after two accepted beats of a five-beat frame.
    pop_q.delete(); fd_cnt = 0;
    @(negedge axis_clk);
    en = 1; rd_en = 0;
    @(negedge axis_clk);
    en = 0; sm_tvalid = 1; sm_tdata = 32'hB1;
    @(negedge axis_clk);
    sm_tdata = 32'hB2;
    @(negedge axis_clk);
    sm_tdata = 32'hB3;
    #1;
    chk("mid_level_pre", 32'(fifo_level), 32'd2);
    #2;
    axistream_r_rst = 1'b1;
    #1;
    chk("mid_tready", 32'(sm_tready), 32'd0);
    chk("mid_rvalid", 32'(rd_valid), 32'd0);
    chk("mid_level", 32'(fifo_level), 32'd0);
    @(negedge axis_clk);
    sm_tvalid = 0;
    @(negedge axis_clk);
    axistream_r_rst = 1'b0;
    repeat (3) @(negedge axis_clk);
    chk("mid_no_fd", 32'(fd_cnt), 32'd0);
    chk("mid_wc", 32'(word_cnt), 32'd0);

    en = 1; rd_en = 1;
    for (int i = 0, g = 0; i < 3 && g < 50; g++) begin
      @(negedge axis_clk);
      en = 0; sm_tvalid = 1; sm_tdata = 32'hC0 + 32'(i); sm_tlast = (i == 2);
      #1;
      if (sm_tready) i++;
    end
    @(negedge axis_clk);
    sm_tvalid = 0; sm_tlast = 0;
    wait_done("post_done", 20);
    @(negedge axis_clk);
    chk("post_wc", 32'(word_cnt), 32'd3);
    chk("post_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("post_pop_cnt", 32'(pop_q.size()), 32'd3);
    for (int i = 0; i < pop_q.size() && i < 3; i++)
      chk($sformatf("post_data_%0d", i), pop_q[i], 32'hC0 + 32'(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
